// File: rtl/ddsm_pkg.sv
// ---------------------------------------------------------------------------
// ddsm_pkg
//   Shared definitions for the staggered-modulator FCW controller.
//   - state_t        : controller FSM encodings (exposed on o_state for debug)
//   - *_DEF          : default parameter values
//   - SEG_*          : segment indices inside a full-width FCW (0 = least significant)
//   - seg_base()     : bit offset of a segment inside the FCW
// ---------------------------------------------------------------------------
package ddsm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_RUN    = 3'd2,
        ST_UPDATE = 3'd3,
        ST_DRAIN  = 3'd4
    } state_t;

    localparam int P_INPUT_WIDTH_DEF = 6;
    localparam int P_SETTLE_DEF      = 3;
    localparam int P_CNT_WIDTH_DEF   = 16;

    // Segment order inside the FCW, from least to most significant.
    localparam int SEG_COUNT = 4;
    localparam int SEG_LSB   = 0;
    localparam int SEG_ISB2  = 1;
    localparam int SEG_ISB1  = 2;
    localparam int SEG_MSB   = 3;

    // Lowest bit of segment idx in an FCW built from segments of the given width.
    function automatic int seg_base(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/ddsm_fcw_ctrl.sv
// ---------------------------------------------------------------------------
// ddsm_fcw_ctrl
//   Front-end controller for the four-segment staggered modulator input stage.
//   Takes full-width frequency control words from a host over valid/ready,
//   splits them into msb/isb1/isb2/lsb segments and holds them. Sequences
//   modulator enable, fill and flush so that a new word is only taken once
//   the staggered segment delays have finished carrying the previous one.
//
// Ports
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_fcw, i_fcw_valid        host word and its valid
//   o_fcw_ready               word can be taken this cycle (combinational)
//   i_stop                    level request for an orderly shutdown
//   o_msb/o_isb1/o_isb2/o_lsb held segments towards the input stage
//   o_mod_en                  modulator stage enable
//   o_settled                 pipeline carries only the current word
//   o_busy                    controller is not idle
//   o_word_cnt                number of accepted words (wrapping)
//   o_state                   FSM state encoding (debug)
// ---------------------------------------------------------------------------
module ddsm_fcw_ctrl
    import ddsm_pkg::*;
#(
    parameter int P_INPUT_WIDTH = P_INPUT_WIDTH_DEF,
    parameter int P_SETTLE      = P_SETTLE_DEF,
    parameter int P_CNT_WIDTH   = P_CNT_WIDTH_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [4*P_INPUT_WIDTH-1:0] i_fcw,
    input  logic                       i_fcw_valid,
    output logic                       o_fcw_ready,
    input  logic                       i_stop,
    output logic [P_INPUT_WIDTH-1:0]   o_msb,
    output logic [P_INPUT_WIDTH-1:0]   o_isb1,
    output logic [P_INPUT_WIDTH-1:0]   o_isb2,
    output logic [P_INPUT_WIDTH-1:0]   o_lsb,
    output logic                       o_mod_en,
    output logic                       o_settled,
    output logic                       o_busy,
    output logic [P_CNT_WIDTH-1:0]     o_word_cnt,
    output logic [2:0]                 o_state
);

    // The settle counter only ever holds P_SETTLE-1 down to 0.
    localparam int              CW          = (P_SETTLE > 1) ? $clog2(P_SETTLE) : 1;
    localparam logic [CW-1:0]   SETTLE_LOAD = CW'(P_SETTLE - 1);

    state_t                   state_reg, state_next;
    logic [CW-1:0]            settle_reg, settle_next;
    logic                     stop_pend_reg, stop_pend_next;
    logic [P_CNT_WIDTH-1:0]   word_cnt_reg;

    logic [P_INPUT_WIDTH-1:0] seg_in  [SEG_COUNT];
    logic [P_INPUT_WIDTH-1:0] seg_reg [SEG_COUNT];

    logic xfer;
    logic seg_load;
    logic seg_clear;

    // Ready is withheld during reset so that a word presented with reset
    // asserted is never considered transferred.
    assign o_fcw_ready = ((state_reg == ST_IDLE) || (state_reg == ST_RUN)) && !i_stop && !i_rst;
    assign xfer        = i_fcw_valid && o_fcw_ready;

    // ------------------------------------------------------------------
    // FCW split and segment hold registers. All four segments load on the
    // same edge; the stagger itself is implemented downstream.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < SEG_COUNT; gi++) begin : g_seg
            assign seg_in[gi] = i_fcw[seg_base(gi, P_INPUT_WIDTH) +: P_INPUT_WIDTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    seg_reg[gi] <= '0;
                end else if (seg_clear) begin
                    seg_reg[gi] <= '0;
                end else if (seg_load) begin
                    seg_reg[gi] <= seg_in[gi];
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // State, settle counter, pending stop and word counter
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg     <= ST_IDLE;
            settle_reg    <= '0;
            stop_pend_reg <= 1'b0;
            word_cnt_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            settle_reg    <= settle_next;
            stop_pend_reg <= stop_pend_next;
            if (xfer) begin
                word_cnt_reg <= word_cnt_reg + P_CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next     = state_reg;
        settle_next    = settle_reg;
        stop_pend_next = stop_pend_reg;
        seg_load       = 1'b0;
        seg_clear      = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // i_stop has no effect here beyond blocking ready.
                if (xfer) begin
                    state_next  = ST_FILL;
                    settle_next = SETTLE_LOAD;
                    seg_load    = 1'b1;
                end
            end

            ST_FILL, ST_UPDATE: begin
                // A stop arriving mid-settle is remembered and honoured only
                // once the current word has fully propagated.
                if (i_stop) begin
                    stop_pend_next = 1'b1;
                end
                if (settle_reg == '0) begin
                    if (stop_pend_reg || i_stop) begin
                        state_next  = ST_DRAIN;
                        settle_next = SETTLE_LOAD;
                        seg_clear   = 1'b1;
                    end else begin
                        state_next  = ST_RUN;
                    end
                end else begin
                    settle_next = settle_reg - CW'(1);
                end
            end

            ST_RUN: begin
                // Ready is low while i_stop is high, so a simultaneous word
                // is never taken; the stop wins.
                if (i_stop) begin
                    state_next  = ST_DRAIN;
                    settle_next = SETTLE_LOAD;
                    seg_clear   = 1'b1;
                end else if (xfer) begin
                    state_next  = ST_UPDATE;
                    settle_next = SETTLE_LOAD;
                    seg_load    = 1'b1;
                end
            end

            ST_DRAIN: begin
                // Zero segments are flushed through with the modulator still
                // enabled for the full settle time.
                if (settle_reg == '0) begin
                    state_next     = ST_IDLE;
                    stop_pend_next = 1'b0;
                end else begin
                    settle_next = settle_reg - CW'(1);
                end
            end

            default: begin
                state_next     = ST_IDLE;
                settle_next    = '0;
                stop_pend_next = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: all decoded from registered state, so they change only on
    // the clock edge.
    // ------------------------------------------------------------------
    assign o_msb      = seg_reg[SEG_MSB];
    assign o_isb1     = seg_reg[SEG_ISB1];
    assign o_isb2     = seg_reg[SEG_ISB2];
    assign o_lsb      = seg_reg[SEG_LSB];
    assign o_mod_en   = (state_reg != ST_IDLE);
    assign o_busy     = (state_reg != ST_IDLE);
    assign o_settled  = (state_reg == ST_RUN);
    assign o_word_cnt = word_cnt_reg;
    assign o_state    = state_reg;

endmodule

// File: tb/tb_ddsm_fcw_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddsm_fcw_ctrl
//   Directed bench for ddsm_fcw_ctrl (W=6, settle=3). Each stimulus row
//   drives one cycle of inputs and queues the hand-computed outputs expected
//   in that same cycle; a monitor pops and compares on the falling edge.
//   A second instance with a 2-bit word counter shares the stimulus and
//   exercises counter wrap-around.
// ---------------------------------------------------------------------------
module tb_ddsm_fcw_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [23:0] fcw;
    logic        fcw_valid;
    logic        stop;

    logic        fcw_ready, mod_en, settled, busy;
    logic [5:0]  msb, isb1, isb2, lsb;
    logic [15:0] word_cnt;
    logic [2:0]  state;

    logic        w_fcw_ready, w_mod_en, w_settled, w_busy;
    logic [5:0]  w_msb, w_isb1, w_isb2, w_lsb;
    logic [1:0]  w_word_cnt;
    logic [2:0]  w_state;

    always #5 clk = ~clk;

    ddsm_fcw_ctrl #(.P_INPUT_WIDTH(6), .P_SETTLE(3), .P_CNT_WIDTH(16)) dut (
        .i_clk(clk), .i_rst(rst), .i_fcw(fcw), .i_fcw_valid(fcw_valid),
        .o_fcw_ready(fcw_ready), .i_stop(stop),
        .o_msb(msb), .o_isb1(isb1), .o_isb2(isb2), .o_lsb(lsb),
        .o_mod_en(mod_en), .o_settled(settled), .o_busy(busy),
        .o_word_cnt(word_cnt), .o_state(state)
    );

    ddsm_fcw_ctrl #(.P_INPUT_WIDTH(6), .P_SETTLE(3), .P_CNT_WIDTH(2)) u_wrap (
        .i_clk(clk), .i_rst(rst), .i_fcw(fcw), .i_fcw_valid(fcw_valid),
        .o_fcw_ready(w_fcw_ready), .i_stop(stop),
        .o_msb(w_msb), .o_isb1(w_isb1), .o_isb2(w_isb2), .o_lsb(w_lsb),
        .o_mod_en(w_mod_en), .o_settled(w_settled), .o_busy(w_busy),
        .o_word_cnt(w_word_cnt), .o_state(w_state)
    );

    typedef struct {
        logic        rdy;
        logic [2:0]  st;
        logic [23:0] seg;
        logic [15:0] cnt;
        int          row;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   bad    = 0;
    int   row_id = 0;

    task automatic check(input string name, input int row, input logic [31:0] got,
                         input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL row%0d %s got=%0h want=%0h", row, name, got, want);
        end
    endtask

    // Monitor: compare one queued expectation per cycle on the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                $display("row %0d: state=%0d ready=%0b seg=%06h cnt=%0d",
                         e.row, state, fcw_ready, {msb, isb1, isb2, lsb}, word_cnt);
                check("state",    e.row, 32'(state),                    32'(e.st));
                check("ready",    e.row, 32'(fcw_ready),                32'(e.rdy));
                check("mod_en",   e.row, 32'(mod_en),                   32'(e.st != 3'd0));
                check("busy",     e.row, 32'(busy),                     32'(e.st != 3'd0));
                check("settled",  e.row, 32'(settled),                  32'(e.st == 3'd2));
                check("segments", e.row, 32'({msb, isb1, isb2, lsb}),   32'(e.seg));
                check("word_cnt", e.row, 32'(word_cnt),                 32'(e.cnt));
                check("w_state",  e.row, 32'(w_state),                  32'(e.st));
                check("w_ready",  e.row, 32'(w_fcw_ready),              32'(e.rdy));
                check("w_mod_en", e.row, 32'({w_mod_en, w_busy, w_settled}),
                      32'({e.st != 3'd0, e.st != 3'd0, e.st == 3'd2}));
                check("w_segs",   e.row, 32'({w_msb, w_isb1, w_isb2, w_lsb}), 32'(e.seg));
                check("w_cnt",    e.row, 32'(w_word_cnt),               32'(e.cnt[1:0]));
            end
        end
    end

    // Drive n identical cycles of inputs and queue the outputs expected in each.
    task automatic drive(input int n, input bit r, input bit v, input bit s,
                         input logic [23:0] f, input logic [2:0] st, input bit rdy,
                         input logic [23:0] seg, input logic [15:0] cnt);
        repeat (n) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst       = r;
            fcw_valid = v;
            stop      = s;
            fcw       = f;
            row_id++;
            e.rdy = rdy;
            e.st  = st;
            e.seg = seg;
            e.cnt = cnt;
            e.row = row_id;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        rst       = 1'b1;
        fcw_valid = 1'b1;
        stop      = 1'b0;
        fcw       = 24'hABCDEF;

        //    n  rst v  stop fcw         state rdy seg          cnt
        // Reset with valid high: everything zero, ready low; release -> ready.
        drive(1, 1, 1, 0, 24'hABCDEF, 3'd0, 1, 24'h000000, 16'd0);
        // (row 1 ready must be low: fix below via dedicated row list)
        row_id = row_id;
    end

    // Main directed sequence runs after the first row above has been queued.
    initial begin
        #2;
        wait (row_id == 1);
        // Correct the first row's ready expectation: reset forces ready low.
        exp_q[0].rdy = 1'b0;

        drive(1, 0, 0, 0, 24'h0,      3'd0, 1, 24'h000000, 16'd0);
        // First word in IDLE: 3 fill cycles, settled on the 4th.
        drive(1, 0, 1, 0, 24'hABCDEF, 3'd0, 1, 24'h000000, 16'd0);
        drive(3, 0, 0, 0, 24'h0,      3'd1, 0, 24'hABCDEF, 16'd1);
        drive(1, 0, 0, 0, 24'h0,      3'd2, 1, 24'hABCDEF, 16'd1);
        // Back-to-back words with valid held high: one per 4 cycles.
        drive(1, 0, 1, 0, 24'h123456, 3'd2, 1, 24'hABCDEF, 16'd1);
        drive(3, 0, 1, 0, 24'h654321, 3'd3, 0, 24'h123456, 16'd2);
        drive(1, 0, 1, 0, 24'h654321, 3'd2, 1, 24'h123456, 16'd2);
        drive(3, 0, 1, 0, 24'h0FF0F0, 3'd3, 0, 24'h654321, 16'd3);
        drive(1, 0, 1, 0, 24'h0FF0F0, 3'd2, 1, 24'h654321, 16'd3);
        drive(3, 0, 0, 0, 24'h0,      3'd3, 0, 24'h0FF0F0, 16'd4);
        drive(1, 0, 0, 0, 24'h0,      3'd2, 1, 24'h0FF0F0, 16'd4);
        // Stop with valid in RUN: word refused, drain 3 cycles, back to IDLE.
        drive(1, 0, 1, 1, 24'h111111, 3'd2, 0, 24'h0FF0F0, 16'd4);
        drive(3, 0, 0, 0, 24'h0,      3'd4, 0, 24'h000000, 16'd4);
        drive(1, 0, 0, 0, 24'h0,      3'd0, 1, 24'h000000, 16'd4);
        // Stop in IDLE only blocks ready.
        drive(1, 0, 0, 1, 24'h0,      3'd0, 0, 24'h000000, 16'd4);
        drive(1, 0, 0, 0, 24'h0,      3'd0, 1, 24'h000000, 16'd4);
        // Stop pulse in 2nd UPDATE cycle: settle completes, then DRAIN.
        drive(1, 0, 1, 0, 24'h2468AC, 3'd0, 1, 24'h000000, 16'd4);
        drive(3, 0, 0, 0, 24'h0,      3'd1, 0, 24'h2468AC, 16'd5);
        drive(1, 0, 1, 0, 24'h13579B, 3'd2, 1, 24'h2468AC, 16'd5);
        drive(1, 0, 0, 0, 24'h0,      3'd3, 0, 24'h13579B, 16'd6);
        drive(1, 0, 0, 1, 24'h0,      3'd3, 0, 24'h13579B, 16'd6);
        drive(1, 0, 0, 0, 24'h0,      3'd3, 0, 24'h13579B, 16'd6);
        drive(3, 0, 0, 0, 24'h0,      3'd4, 0, 24'h000000, 16'd6);
        drive(1, 0, 0, 0, 24'h0,      3'd0, 1, 24'h000000, 16'd6);
        // Pending stop was cleared: next word settles into RUN; then reset in DRAIN.
        drive(1, 0, 1, 0, 24'hFFFFFF, 3'd0, 1, 24'h000000, 16'd6);
        drive(3, 0, 0, 0, 24'h0,      3'd1, 0, 24'hFFFFFF, 16'd7);
        drive(1, 0, 0, 1, 24'h0,      3'd2, 0, 24'hFFFFFF, 16'd7);
        drive(1, 1, 0, 0, 24'h0,      3'd4, 0, 24'h000000, 16'd7);
        drive(1, 0, 0, 0, 24'h0,      3'd0, 1, 24'h000000, 16'd0);

        // Let the monitor consume everything, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain_queue got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
